// File: rtl/gate_input_sequencer.sv
// Operand source for the two-input gate block: debounced manual switches or an
// automatic 00->01->10->11 sweep, with a one-cycle strobe whenever {a,b} changes.
module gate_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int DWELL_CYCLES    = 100000000,
  parameter int DWELL_W         = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_a,
  input  logic       sw_b,
  input  logic       auto_en,
  output logic       a,
  output logic       b,
  output logic       ab_valid,
  output logic       mode_auto,
  output logic [1:0] combo_idx
);

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

  localparam logic [CNT_W-1:0]   DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  // Channel order in the vectors below: [0]=sw_a, [1]=sw_b, [2]=auto_en.
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       stable;
  logic [CNT_W-1:0] db_cnt [3];

  assign raw = {auto_en, sw_b, sw_a};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the debounce counters are few, so they get a real reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  state_t             state;
  state_t             state_next;
  logic [DWELL_W-1:0] dwell;
  logic [DWELL_W-1:0] dwell_next;
  logic [1:0]         idx_next;
  logic               a_next;
  logic               b_next;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    dwell_next = '0;
    idx_next   = 2'd0;
    unique case (state)
      MANUAL: begin
        if (stable[2]) state_next = AUTO;
      end
      AUTO: begin
        // A mode change takes priority over a coincident dwell terminal count.
        if (!stable[2]) begin
          state_next = MANUAL;
        end else if (dwell == DWELL_LAST) begin
          idx_next = combo_idx + 2'd1;
        end else begin
          dwell_next = dwell + DWELL_W'(1);
          idx_next   = combo_idx;
        end
      end
      default: state_next = MANUAL;
    endcase
    a_next = (state_next == AUTO) ? idx_next[1] : stable[0];
    b_next = (state_next == AUTO) ? idx_next[0] : stable[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MANUAL;
      dwell     <= '0;
      combo_idx <= 2'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      ab_valid  <= 1'b0;
      mode_auto <= 1'b0;
    end else begin
      state     <= state_next;
      dwell     <= dwell_next;
      combo_idx <= idx_next;
      a         <= a_next;
      b         <= b_next;
      ab_valid  <= ({a_next, b_next} != {a, b});
      mode_auto <= (state_next == AUTO);
    end
  end

endmodule

// File: tb/tb_gate_input_sequencer.sv
// Directed bench for gate_input_sequencer with DEBOUNCE_CYCLES=4, DWELL_CYCLES=8:
// a vector table for manual-mode debounce plus hand sequences for reset and auto mode.
module tb_gate_input_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_a = 1'b0;
  logic       sw_b = 1'b0;
  logic       auto_en = 1'b0;
  logic       a;
  logic       b;
  logic       ab_valid;
  logic       mode_auto;
  logic [1:0] combo_idx;

  int total = 0;
  int bad   = 0;

  gate_input_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .DWELL_CYCLES(8),
    .DWELL_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_a(sw_a),
    .sw_b(sw_b),
    .auto_en(auto_en),
    .a(a),
    .b(b),
    .ab_valid(ab_valid),
    .mode_auto(mode_auto),
    .combo_idx(combo_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sw_a;
    logic       sw_b;
    logic       auto_en;
    int         cycles;
    logic       ea;
    logic       eb;
    logic       ev;
    logic       em;
    logic [1:0] eidx;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ea, input logic eb,
                           input logic ev, input logic em, input logic [1:0] eidx);
    check({tag, ".a"}, int'(a), int'(ea));
    check({tag, ".b"}, int'(b), int'(eb));
    check({tag, ".ab_valid"}, int'(ab_valid), int'(ev));
    check({tag, ".mode_auto"}, int'(mode_auto), int'(em));
    check({tag, ".combo_idx"}, int'(combo_idx), int'(eidx));
  endtask

  // Advance one rising edge and sample shortly after it.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic sa, input logic sb, input logic ae);
    rst     = 1'b1;
    sw_a    = sa;
    sw_b    = sb;
    auto_en = ae;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int waited;
    // Reset with switches high
    tick(2);
    rst  = 1'b0;
    sw_a = 1'b1;
    sw_b = 1'b1;
    waited = 0;
    while (!(a && b) && waited < 20) begin
      tick();
      waited++;
    end
    check("rst.wait_ab_high", int'(a && b), 1);
    #2 rst = 1'b1;
    #1 check_all("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst.release_no_pulse%0d", i), int'(ab_valid), 0);
    end
    do_reset(1'b0, 1'b0, 1'b0);

    // Manual-mode vectors: inputs applied, then `cycles` edges, then compare
    vecs[0] = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0,  3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b0,  6, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b0,  7, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[7] = '{1'b1, 1'b1, 1'b0,  6, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[8] = '{1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[9] = '{1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    for (int i = 0; i < 10; i++) begin
      sw_a    = vecs[i].sw_a;
      sw_b    = vecs[i].sw_b;
      auto_en = vecs[i].auto_en;
      tick(vecs[i].cycles);
      check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ev,
                vecs[i].em, vecs[i].eidx);
    end

    // Auto sweep from switches at 00; entry edge is the 7th
    do_reset(1'b0, 1'b0, 1'b1);
    tick(6);
    check("sweep.pre_entry_mode", int'(mode_auto), 0);
    tick();
    check_all("sweep.entry", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    for (int t = 1; t < 40; t++) begin
      logic [1:0] ei;
      ei = 2'((t / 8) % 4);
      tick();
      check_all($sformatf("sweep.t%0d", t), ei[1], ei[0], (t % 8) == 0, 1'b1, ei);
    end

    // Exit at index 3 with switches at 10: single pulse
    do_reset(1'b1, 1'b0, 1'b1);
    tick(7);
    check_all("exit3.entry", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    tick(24);
    auto_en = 1'b0;
    tick(6);
    check_all("exit3.before", 1'b1, 1'b1, 1'b0, 1'b1, 2'd3);
    tick();
    check_all("exit3.edge", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    check_all("exit3.after", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    // Exit at index 2 coinciding with dwell terminal count: no pulse, no increment
    do_reset(1'b1, 1'b0, 1'b1);
    tick(7);
    tick(17);
    auto_en = 1'b0;
    tick(6);
    check_all("exit2.before", 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    tick();
    check_all("exit2.edge", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    // Reset asserted mid-sweep at index 2, auto_en kept high
    do_reset(1'b0, 1'b0, 1'b1);
    tick(7 + 16);
    check_all("rstauto.idx2", 1'b1, 1'b0, 1'b1, 1'b1, 2'd2);
    #2 rst = 1'b1;
    #1 check_all("rstauto.async", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    rst = 1'b0;
    tick(6);
    check("rstauto.pre_reentry_mode", int'(mode_auto), 0);
    tick();
    check_all("rstauto.reentry", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_input_sequencer.md
Name: gate_input_sequencer

Overview:
- Upstream stimulus stage for the two-input logic-gate block; produces its `a` and `b` operands.
- Manual mode: conditions raw board switches (2-FF synchroniser plus debounce) and presents clean levels.
- Auto mode: sweeps {a,b} through 00→01→10→11 at a programmable dwell, so every gate output can be shown without touching switches.
- Emits a one-cycle strobe whenever the operand pair changes, for downstream capture/display.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a new switch level (10 ms at 100 MHz); legal range ≥1.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- DWELL_CYCLES, 100000000, clocks each combination is held in auto mode; legal range ≥2.
- DWELL_W, 27, dwell counter width; must satisfy 2^DWELL_W ≥ DWELL_CYCLES.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw_a  input  1  raw, asynchronous, bouncy switch for operand a.
- sw_b  input  1  raw, asynchronous, bouncy switch for operand b.
- auto_en  input  1  raw, asynchronous switch; 1 selects auto sweep.
- a  output  1  registered operand a to the gate block.
- b  output  1  registered operand b to the gate block.
- ab_valid  output  1  one-cycle pulse: {a,b} changed on the preceding edge.
- mode_auto  output  1  registered status; 1 while in AUTO.
- combo_idx  output  2  current sweep index in AUTO; 0 in MANUAL.

Behaviour:
- Reset: while rst=1, all flops clear asynchronously and immediately, including synchroniser stages, debounce counters and debounced levels.
  - Output values during reset: a=0, b=0, ab_valid=0, mode_auto=0, combo_idx=0, state=MANUAL.
  - ab_valid is not pulsed on reset release.
- Synchroniser: each of sw_a, sw_b and auto_en passes through its own 2-FF synchroniser.
- Debounce, identical per channel:
  - Counter clears whenever the synced input equals the stable level.
  - Counter increments while they differ.
  - When the count equals DEBOUNCE_CYCLES-1 and the input still differs, the stable level takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES samples is discarded.
- Output register: a, b, mode_auto and combo_idx are registered one edge after the stable levels and FSM.
  - Raw edge to output latency = DEBOUNCE_CYCLES+3 rising edges.
- FSM states: MANUAL, AUTO.
  - MANUAL: {a,b} ← {stable_a, stable_b}; combo_idx=0; dwell counter held at 0. Debounced auto_en=1 → AUTO.
  - AUTO entry cycle: combo_idx=0 and dwell count=0, so {a,b}=00 on entry.
  - AUTO steady: dwell counts 0..DWELL_CYCLES-1. At terminal count, dwell wraps to 0 and combo_idx increments mod 4 (3→0 wraps).
  - AUTO outputs: a=combo_idx[1], b=combo_idx[0]. Debounced auto_en=0 → MANUAL.
  - AUTO exit: on the next edge {a,b} takes the debounced switch values and combo_idx clears.
  - Mode change coincident with dwell terminal count: the mode change wins and no index increment is applied.
- ab_valid:
  - Registered; equals 1 on the cycle after any edge where the new {a,b} differs from the old {a,b}.
  - A simultaneous a and b change gives a single pulse.
  - A mode switch that leaves {a,b} unchanged gives no pulse.
  - The pulse is never wider than 1 cycle unless {a,b} changes on consecutive edges.
- Reset asserted mid-sweep or mid-debounce aborts the operation. After release, debounce restarts from stable=0 and the sweep restarts from index 0.

Test Plan (DEBOUNCE_CYCLES=4, DWELL_CYCLES=8):
1. Reset:
   - Drive sw_a=sw_b=1 and wait until a=b=1.
   - Assert rst between clock edges → a, b, ab_valid, mode_auto, combo_idx go 0 before the next edge.
   - Release rst → no ab_valid pulse.
2. Debounce reject/accept:
   - sw_a high for 3 cycles, then low → a stays 0, ab_valid stays 0.
   - sw_a held high → a=1 after the 7th rising edge, ab_valid=1 for exactly that cycle, then 0.
3. Simultaneous change:
   - sw_a and sw_b rise on the same cycle → both rise on the same edge with a single ab_valid pulse.
4. Auto sweep:
   - auto_en held high, switches at 00 → mode_auto=1 with no pulse on entry.
   - {a,b} = 00, 01, 10, 11, 00, each held exactly 8 cycles; ab_valid pulses at each change; combo_idx = 0,1,2,3,0.
5. Auto exit:
   - sw_a=1, sw_b=0; drop auto_en while at index 3 (11) → {a,b}=10 one edge after debounced auto_en=0.
   - Single ab_valid pulse; mode_auto=0; combo_idx=0.
   - Repeat exit at index 2 (10) → no ab_valid pulse.
6. Reset in AUTO:
   - Assert rst at index 2 → all outputs 0 and state MANUAL.
   - With auto_en still high after release, AUTO re-enters at combo_idx=0 after 7 edges.
